// File: rtl/wishbone_bus_if_pkg.sv
// Shared types and constants for the CPU-port to Wishbone classic master bridge.
// State encodings match the legacy WB_* defines so traces stay comparable.
package wishbone_bus_if_pkg;

   localparam int unsigned REG_BUS_W = 32;
   localparam int unsigned SEL_W     = 4;
   localparam int unsigned STALL_W   = 6;

   localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      WB_IDLE           = 2'b00,
      WB_BUSY           = 2'b01,
      WB_WAIT_FOR_STALL = 2'b11
   } wb_state_e;

endpackage

// File: rtl/wishbone_bus_if.sv
// Converts a single-cycle CPU memory request into a Wishbone B.4 classic transfer,
// stalling the pipeline until ack and holding read data while the pipeline is frozen.
module wishbone_bus_if
   import wishbone_bus_if_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [STALL_W-1:0]   stall_i,
   input  logic                 flush_i,
   input  logic                 cpu_ce_i,
   input  logic [REG_BUS_W-1:0] cpu_addr_i,
   input  logic [REG_BUS_W-1:0] cpu_data_i,
   input  logic                 cpu_we_i,
   input  logic [SEL_W-1:0]     cpu_sel_i,
   output logic [REG_BUS_W-1:0] cpu_data_o,
   output logic                 stallreq,
   input  logic [REG_BUS_W-1:0] wishbone_data_i,
   input  logic                 wishbone_ack_i,
   output logic [REG_BUS_W-1:0] wishbone_addr_o,
   output logic [REG_BUS_W-1:0] wishbone_data_o,
   output logic                 wishbone_we_o,
   output logic [SEL_W-1:0]     wishbone_sel_o,
   output logic                 wishbone_stb_o,
   output logic                 wishbone_cyc_o,
   output logic                 bus_err_o
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   wb_state_e              state_q, state_d;
   logic [REG_BUS_W-1:0]   addr_q, addr_d;
   logic [REG_BUS_W-1:0]   wdata_q, wdata_d;
   logic                   we_q, we_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic                   stb_q, stb_d;
   logic                   cyc_q, cyc_d;
   logic [REG_BUS_W-1:0]   rd_buf_q, rd_buf_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   bus_err_q, bus_err_d;

   logic                   stallreq_c;
   logic [REG_BUS_W-1:0]   cpu_data_c;
   logic                   timeout_hit;

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      sel_d      = sel_q;
      stb_d      = stb_q;
      cyc_d      = cyc_q;
      rd_buf_d   = rd_buf_q;
      cnt_d      = cnt_q;
      bus_err_d  = 1'b0;
      stallreq_c = 1'b0;
      cpu_data_c = ZERO_WORD;

      case (state_q)
         WB_IDLE: begin
            if (cpu_ce_i && !flush_i) begin
               addr_d     = cpu_addr_i;
               wdata_d    = cpu_data_i;
               we_d       = cpu_we_i;
               sel_d      = cpu_sel_i;
               stb_d      = 1'b1;
               cyc_d      = 1'b1;
               rd_buf_d   = ZERO_WORD;
               cnt_d      = '0;
               stallreq_c = 1'b1;
               state_d    = WB_BUSY;
            end
         end

         WB_BUSY: begin
            // ack outranks flush: the bus transfer must complete once acknowledged
            if (wishbone_ack_i) begin
               stb_d   = 1'b0;
               cyc_d   = 1'b0;
               addr_d  = ZERO_WORD;
               wdata_d = ZERO_WORD;
               we_d    = 1'b0;
               sel_d   = '0;
               if (!we_q) begin
                  rd_buf_d   = wishbone_data_i;
                  cpu_data_c = wishbone_data_i;
               end
               state_d = (stall_i != '0) ? WB_WAIT_FOR_STALL : WB_IDLE;
            end else if (flush_i || timeout_hit) begin
               stb_d     = 1'b0;
               cyc_d     = 1'b0;
               addr_d    = ZERO_WORD;
               wdata_d   = ZERO_WORD;
               we_d      = 1'b0;
               sel_d     = '0;
               bus_err_d = !flush_i;
               state_d   = WB_IDLE;
            end else begin
               cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
               stallreq_c = 1'b1;
            end
         end

         WB_WAIT_FOR_STALL: begin
            cpu_data_c = rd_buf_q;
            if (stall_i == '0) begin
               state_d = WB_IDLE;
            end
         end

         default: begin
            state_d = WB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= WB_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         stb_q     <= 1'b0;
         cyc_q     <= 1'b0;
         rd_buf_q  <= '0;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         stb_q     <= stb_d;
         cyc_q     <= cyc_d;
         rd_buf_q  <= rd_buf_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Reset idles the state register, but a live cpu_ce_i would still raise stallreq without this gate
   assign stallreq   = rst ? 1'b0 : stallreq_c;
   assign cpu_data_o = rst ? ZERO_WORD : cpu_data_c;

   assign wishbone_addr_o = addr_q;
   assign wishbone_data_o = wdata_q;
   assign wishbone_we_o   = we_q;
   assign wishbone_sel_o  = sel_q;
   assign wishbone_stb_o  = stb_q;
   assign wishbone_cyc_o  = cyc_q;
   assign bus_err_o       = bus_err_q;

endmodule
